square_share_sched: RTL

Time-multiplexes one `squaring_circuit_8bit` instance among `N_REQ` neuron update units, each of which needs one v² term per simulation step. A step-level FSM serves every enabled requester exactly once per step, in round-robin order, at one grant per cycle. It then signals `step_done` to the network sequencer. The block sits between the neuron array and the shared squarer, replacing per-neuron squarers.

---
 rtl/square_sched_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/squaring_circuit_8bit.sv | 16 +
 rtl/square_share_sched.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/square_sched_pkg.sv
// Shared definitions for the shared-squarer step scheduler.
package square_sched_pkg;

  // Operand and result widths fixed by the shared squarer.
  localparam int OP_W = 8;
  localparam int SQ_W = 16;

  // Default number of neuron update units sharing one squarer.
  localparam int N_REQ_DEF = 4;

  // Step-level scheduler states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

endpackage : square_sched_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// the pointer, searching upward and wrapping around.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] winner,
  output logic             any_grant
);

  int idx;

  // Walk the requesters starting from the pointer; the first hit wins.
  always_comb begin
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        winner     = IDX_W'(idx);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/squaring_circuit_8bit.sv
// Approximate 8-bit squarer. Negative operands use their ones' complement
// magnitude, so -v squares to (|v|-1)^2, which the neuron model expects.
module squaring_circuit_8bit (
  input  logic [7:0]  operand,
  output logic [15:0] square
);

  logic [7:0] mag;

  // Take the ones' complement magnitude and square it; it never exceeds 127.
  always_comb begin
    mag    = operand[7] ? ~operand : operand;
    square = {8'd0, mag} * {8'd0, mag};
  end

endmodule : squaring_circuit_8bit

// File: rtl/square_share_sched.sv
// Time-multiplexes one squarer among N_REQ neuron update units. Every
// enabled requester is served once per step in round-robin order, one grant
// per cycle, through a two-stage pipeline around the squarer.
module square_share_sched
  import square_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_start,
  input  logic [N_REQ-1:0]      req_en,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*OP_W-1:0] req_operand,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  resp_valid,
  output logic [IDX_W-1:0]      resp_id,
  output logic [SQ_W-1:0]       resp_square,
  output logic                  busy,
  output logic                  step_done
);

  sched_state_t     state;
  logic [N_REQ-1:0] pending;
  logic [IDX_W-1:0] rr_ptr;

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_winner;
  logic             arb_any;
  logic             grant_fire;
  logic [N_REQ-1:0] pending_after;
  logic [IDX_W-1:0] rr_ptr_next;
  logic [OP_W-1:0]  sel_operand;

  logic             a_valid;
  logic [IDX_W-1:0] a_id;
  logic [OP_W-1:0]  a_operand;
  logic [SQ_W-1:0]  sq_result;

  logic             b_valid;
  logic [IDX_W-1:0] b_id;
  logic [SQ_W-1:0]  b_square;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (pending & req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .winner    (arb_winner),
    .any_grant (arb_any)
  );

  // Grants are only issued in SERVE; the operand mux is driven by the one-hot
  // grant so req_operand reaches nothing but the stage A register.
  always_comb begin
    grant_fire    = (state == SERVE) && arb_any;
    req_ready     = (state == SERVE) ? arb_grant : '0;
    pending_after = pending & ~arb_grant;
    rr_ptr_next   = (arb_winner == IDX_W'(N_REQ - 1)) ? '0 : arb_winner + 1'b1;
    sel_operand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_operand = req_operand[i*OP_W +: OP_W];
      end
    end
  end

  // Step FSM: loads the pending mask, retires grants and pulses step_done.
  // DRAIN lasts one cycle: grants have stopped, so the last operand sits in
  // stage A and reaches stage B at the exit edge, making step_done coincide
  // with the final response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      rr_ptr    <= '0;
      step_done <= 1'b0;
    end else begin
      step_done <= 1'b0;
      case (state)
        IDLE: begin
          if (step_start && !step_done) begin
            pending <= req_en;
            state   <= (req_en == '0) ? DRAIN : SERVE;
          end
        end
        SERVE: begin
          if (grant_fire) begin
            pending <= pending_after;
            rr_ptr  <= rr_ptr_next;
            if (pending_after == '0) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          state     <= IDLE;
          step_done <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
        end
      endcase
    end
  end

  squaring_circuit_8bit u_sq (
    .operand (a_operand),
    .square  (sq_result)
  );

  // Two-stage response pipeline: stage A holds the granted operand, stage B
  // the squared result. Reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid   <= 1'b0;
      a_id      <= '0;
      a_operand <= '0;
      b_valid   <= 1'b0;
      b_id      <= '0;
      b_square  <= '0;
    end else begin
      a_valid <= grant_fire;
      if (grant_fire) begin
        a_id      <= arb_winner;
        a_operand <= sel_operand;
      end
      b_valid <= a_valid;
      if (a_valid) begin
        b_id     <= a_id;
        b_square <= sq_result;
      end
    end
  end

  // busy covers the whole step, including the step_done cycle after the FSM
  // has already returned to IDLE.
  always_comb begin
    resp_valid  = b_valid;
    resp_id     = b_id;
    resp_square = b_square;
    busy        = (state != IDLE) || step_done;
  end

endmodule : square_share_sched
